// File: rtl/caf_pkg.sv
// Shared types for the CAF lag scheduler: FSM encoding and a parameter width check.
// Latency: n/a (package). Backpressure: n/a.
// Imported by caf_lag_sched and lag_addr_gen.
package caf_pkg;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_FEED  = 3'd1;
    localparam logic [2:0] ENC_DRAIN = 3'd2;
    localparam logic [2:0] ENC_WAIT  = 3'd3;
    localparam logic [2:0] ENC_EMIT  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ENC_IDLE,
        S_FEED  = ENC_FEED,
        S_DRAIN = ENC_DRAIN,
        S_WAIT  = ENC_WAIT,
        S_EMIT  = ENC_EMIT
    } state_t;

    // True when the address bus can hold the largest y address (k+n) and
    // the lag bus can hold the largest lag index.
    function automatic bit widths_ok(input int length, input int num_lags,
                                     input int addr_bits, input int lag_bits);
        longint addr_need;
        longint lag_need;
        addr_need = longint'(length) + longint'(num_lags) - 2;
        lag_need  = longint'(num_lags) - 1;
        return (length >= 1) && (num_lags >= 1) &&
               (addr_need < (longint'(1) << addr_bits)) &&
               (lag_need < (longint'(1) << lag_bits));
    endfunction

endpackage

// File: rtl/lag_addr_gen.sv
// Sample (n) and lag (k) counters producing x_addr=n and y_addr=k+n.
// Latency: addresses follow the counters combinationally; counters update per step.
// Backpressure: none; counters only move on explicit step_n/step_k.
module lag_addr_gen
    import caf_pkg::*;
#(
    parameter int length    = 16,
    parameter int num_lags  = 8,
    parameter int addr_bits = 8,
    parameter int lag_bits  = 4
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 clear,
    input  logic                 step_n,
    input  logic                 step_k,
    output logic [addr_bits-1:0] x_addr,
    output logic [addr_bits-1:0] y_addr,
    output logic [lag_bits-1:0]  k,
    output logic                 last_n,
    output logic                 last_k
);

    logic [addr_bits-1:0] n;

    // n wraps to 0 after the last sample so idle/drain cycles present lag base addresses.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            n <= '0;
            k <= '0;
        end else if (clear) begin
            n <= '0;
            k <= '0;
        end else if (step_k) begin
            n <= '0;
            k <= k + lag_bits'(1);
        end else if (step_n) begin
            n <= last_n ? '0 : n + addr_bits'(1);
        end
    end

    assign last_n = (n == addr_bits'(length - 1));
    assign last_k = (k == lag_bits'(num_lags - 1));
    assign x_addr = n;
    assign y_addr = n + addr_bits'(k);

endmodule

// File: rtl/caf_lag_sched.sv
// Sweeps lags, streaming x[n] and y[k+n] into dot_prod_pip and emitting each sum tagged with k.
// Latency: per lag = length + 1 + product latency + 1 cycles; first beat 2 cycles after start.
// Backpressure: EMIT holds result stable until m_axis_out_tready; product tready only in WAIT.
module caf_lag_sched
    import caf_pkg::*;
#(
    parameter int x_bits    = 12,
    parameter int y_bits    = 12,
    parameter int sum_bits  = 32,
    parameter int length    = 16,
    parameter int num_lags  = 8,
    parameter int addr_bits = 8,
    parameter int lag_bits  = 4
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [addr_bits-1:0] x_addr,
    output logic [addr_bits-1:0] y_addr,
    input  logic [x_bits-1:0]    x_rd_i,
    input  logic [x_bits-1:0]    x_rd_q,
    input  logic [y_bits-1:0]    y_rd_i,
    input  logic [y_bits-1:0]    y_rd_q,
    output logic                 m_axis_x_tvalid,
    output logic                 m_axis_y_tvalid,
    output logic [x_bits-1:0]    xi,
    output logic [x_bits-1:0]    xq,
    output logic [y_bits-1:0]    yi,
    output logic [y_bits-1:0]    yq,
    input  logic                 s_axis_product_tvalid,
    input  logic [sum_bits-1:0]  i,
    input  logic [sum_bits-1:0]  q,
    output logic                 m_axis_product_tready,
    output logic                 s_axis_out_tvalid,
    output logic [lag_bits-1:0]  out_lag,
    output logic [sum_bits-1:0]  out_i,
    output logic [sum_bits-1:0]  out_q,
    input  logic                 m_axis_out_tready
);

    localparam bit cfg_ok = widths_ok(length, num_lags, addr_bits, lag_bits);

    state_t              state, state_nxt;
    logic                run_n;
    logic                clear, step_n, step_k;
    logic                last_n, last_k;
    logic                smp_vld;
    logic [lag_bits-1:0] k;

    // An instance whose buses cannot hold its address/lag range stays in reset.
    assign run_n = n_reset & cfg_ok;

    lag_addr_gen #(
        .length   (length),
        .num_lags (num_lags),
        .addr_bits(addr_bits),
        .lag_bits (lag_bits)
    ) u_addr (
        .clk    (clk),
        .n_reset(run_n),
        .clear  (clear),
        .step_n (step_n),
        .step_k (step_k),
        .x_addr (x_addr),
        .y_addr (y_addr),
        .k      (k),
        .last_n (last_n),
        .last_k (last_k)
    );

    always_ff @(posedge clk) begin
        if (!run_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        step_n    = 1'b0;
        step_k    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clear     = 1'b1;
                    state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                step_n = 1'b1;
                if (last_n) state_nxt = S_DRAIN;
            end
            S_DRAIN: state_nxt = S_WAIT;
            S_WAIT: begin
                if (s_axis_product_tvalid) state_nxt = S_EMIT;
            end
            S_EMIT: begin
                // done fires in the handshake cycle, so a start seen here is still ignored.
                if (m_axis_out_tready) begin
                    if (!last_k) begin
                        step_k    = 1'b1;
                        state_nxt = S_FEED;
                    end else begin
                        done      = 1'b1;
                        clear     = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy                  = (state != S_IDLE);
    assign m_axis_product_tready = (state == S_WAIT);
    assign s_axis_out_tvalid     = (state == S_EMIT);
    assign m_axis_x_tvalid       = smp_vld;
    assign m_axis_y_tvalid       = smp_vld;

    always_ff @(posedge clk) begin
        if (!run_n) begin
            smp_vld <= 1'b0;
            xi      <= '0;
            xq      <= '0;
            yi      <= '0;
            yq      <= '0;
        end else begin
            smp_vld <= (state == S_FEED);
            if (state == S_FEED) begin
                xi <= x_rd_i;
                xq <= x_rd_q;
                yi <= y_rd_i;
                yq <= y_rd_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!run_n) begin
            out_i   <= '0;
            out_q   <= '0;
            out_lag <= '0;
        end else if ((state == S_WAIT) && s_axis_product_tvalid) begin
            out_i   <= i;
            out_q   <= q;
            out_lag <= k;
        end
    end

endmodule

// File: tb/tb_caf_lag_sched.sv
// Directed bench: dut0 sweeps 3 lags of length 4, dut1 a single lag, each fed by a buffer
// and a behavioural dot product; x=[1,2,3,4], y=[1..6], Q=0.
module tb_caf_lag_sched;

    localparam int LEN = 4;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    logic        start[2], out_rdy[2], inj[2];
    logic        busy[2], done[2];
    logic [7:0]  x_addr[2], y_addr[2];
    logic [11:0] x_rd_i[2], x_rd_q[2], y_rd_i[2], y_rd_q[2];
    logic        mx_vld[2], my_vld[2];
    logic [11:0] xi[2], xq[2], yi[2], yq[2];
    logic        pv[2], pr_rdy[2];
    logic [31:0] pi[2], pq[2];
    logic        so_vld[2];
    logic [3:0]  out_lag[2];
    logic [31:0] out_i[2], out_q[2];

    int vecs = 0;
    int errs = 0;

    caf_lag_sched #(.length(LEN), .num_lags(3)) dut (
        .clk(clk), .n_reset(n_reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .x_addr(x_addr[0]), .y_addr(y_addr[0]),
        .x_rd_i(x_rd_i[0]), .x_rd_q(x_rd_q[0]), .y_rd_i(y_rd_i[0]), .y_rd_q(y_rd_q[0]),
        .m_axis_x_tvalid(mx_vld[0]), .m_axis_y_tvalid(my_vld[0]),
        .xi(xi[0]), .xq(xq[0]), .yi(yi[0]), .yq(yq[0]),
        .s_axis_product_tvalid(pv[0]), .i(pi[0]), .q(pq[0]),
        .m_axis_product_tready(pr_rdy[0]), .s_axis_out_tvalid(so_vld[0]),
        .out_lag(out_lag[0]), .out_i(out_i[0]), .out_q(out_q[0]),
        .m_axis_out_tready(out_rdy[0])
    );

    caf_lag_sched #(.length(LEN), .num_lags(1)) dut1 (
        .clk(clk), .n_reset(n_reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .x_addr(x_addr[1]), .y_addr(y_addr[1]),
        .x_rd_i(x_rd_i[1]), .x_rd_q(x_rd_q[1]), .y_rd_i(y_rd_i[1]), .y_rd_q(y_rd_q[1]),
        .m_axis_x_tvalid(mx_vld[1]), .m_axis_y_tvalid(my_vld[1]),
        .xi(xi[1]), .xq(xq[1]), .yi(yi[1]), .yq(yq[1]),
        .s_axis_product_tvalid(pv[1]), .i(pi[1]), .q(pq[1]),
        .m_axis_product_tready(pr_rdy[1]), .s_axis_out_tvalid(so_vld[1]),
        .out_lag(out_lag[1]), .out_i(out_i[1]), .out_q(out_q[1]),
        .m_axis_out_tready(out_rdy[1])
    );

    // Buffers read combinationally, so the registered sample appears one cycle after its address.
    // Dot product: sums LEN beats, presents the sum 3 cycles after the last beat until accepted.
    for (genvar g = 0; g < 2; g++) begin : g_env
        logic [31:0] acc, sum, prod;
        int          cnt, dly;
        logic        vld;

        assign x_rd_i[g] = (x_addr[g] < 8'd4) ? 12'(x_addr[g]) + 12'd1 : 12'd0;
        assign y_rd_i[g] = (y_addr[g] < 8'd6) ? 12'(y_addr[g]) + 12'd1 : 12'd0;
        assign x_rd_q[g] = 12'd0;
        assign y_rd_q[g] = 12'd0;
        assign prod      = 32'(int'($signed(xi[g])) * int'($signed(yi[g])));

        always @(posedge clk) begin
            if (!n_reset) begin
                acc <= 0; sum <= 0; cnt <= 0; dly <= 0; vld <= 1'b0;
            end else begin
                if (vld && pr_rdy[g]) vld <= 1'b0;
                if (dly == 1) vld <= 1'b1;
                if (dly > 0) dly <= dly - 1;
                if (mx_vld[g]) begin
                    if (cnt == LEN - 1) begin
                        sum <= acc + prod; acc <= 0; cnt <= 0; dly <= 2;
                    end else begin
                        acc <= acc + prod; cnt <= cnt + 1;
                    end
                end
            end
        end

        assign pv[g] = vld | inj[g];
        assign pi[g] = inj[g] ? 32'd999 : sum;
        assign pq[g] = 32'd0;
    end

    // Recorder for dut0; tasks only read it, relative to indices taken at their start.
    logic [3:0]  r_lag[$];
    logic [31:0] r_i[$], r_q[$];
    logic [7:0]  r_xa[$], r_ya[$];
    int          r_runs[$];
    int          r_done = 0, r_skew = 0, run_len = 0;
    logic [7:0]  prev_xa = 8'd0, prev_ya = 8'd0;

    always @(negedge clk) begin
        if (so_vld[0] && out_rdy[0]) begin
            r_lag.push_back(out_lag[0]); r_i.push_back(out_i[0]); r_q.push_back(out_q[0]);
        end
        if (done[0]) r_done++;
        if (mx_vld[0] != my_vld[0]) r_skew++;
        if (mx_vld[0]) begin
            run_len++;
            r_xa.push_back(prev_xa); r_ya.push_back(prev_ya);
        end else if (run_len != 0) begin
            r_runs.push_back(run_len);
            run_len = 0;
        end
        prev_xa = x_addr[0];
        prev_ya = y_addr[0];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        step();
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            step();
            if (done[d]) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        repeat (3) step();
        vecs++;
        if ({busy[0], done[0], mx_vld[0], my_vld[0], pr_rdy[0], so_vld[0]} !== 6'b0) begin
            errs++; $display("FAIL reset_flags: got %b want 000000",
                {busy[0], done[0], mx_vld[0], my_vld[0], pr_rdy[0], so_vld[0]});
        end
        vecs++;
        if ({x_addr[0], y_addr[0]} !== 16'h0) begin
            errs++; $display("FAIL reset_addr: got x=%0d y=%0d want 0", x_addr[0], y_addr[0]);
        end
        vecs++;
        if ({xi[0], xq[0], yi[0], yq[0]} !== 48'h0) begin
            errs++; $display("FAIL reset_samples: got xi=%0d yi=%0d want 0", xi[0], yi[0]);
        end
        vecs++;
        if ({out_lag[0], out_i[0], out_q[0]} !== 68'h0) begin
            errs++; $display("FAIL reset_result: got lag=%0d i=%0d q=%0d want 0",
                out_lag[0], out_i[0], out_q[0]);
        end
        vecs++;
        if ({busy[1], done[1], so_vld[1]} !== 3'b0) begin
            errs++; $display("FAIL reset_dut1: got %b want 000", {busy[1], done[1], so_vld[1]});
        end
        n_reset = 1'b1;
        repeat (2) step();
        vecs++;
        if (busy[0] !== 1'b0) begin
            errs++; $display("FAIL idle_no_start: busy=%b want 0", busy[0]);
        end
    endtask

    task automatic test_basic_sweep();
        int b_res, b_done;
        bit to;
        b_res = r_lag.size(); b_done = r_done;
        out_rdy[0] = 1'b1;
        pulse_start(0);
        vecs++;
        if ({busy[0], mx_vld[0], x_addr[0], y_addr[0]} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            errs++; $display("FAIL start_t1: busy=%b vld=%b x=%0d y=%0d want 1 0 0 0",
                busy[0], mx_vld[0], x_addr[0], y_addr[0]);
        end
        step();
        vecs++;
        if ({mx_vld[0], xi[0], yi[0]} !== {1'b1, 12'd1, 12'd1}) begin
            errs++; $display("FAIL first_beat: vld=%b xi=%0d yi=%0d want 1 1 1",
                mx_vld[0], xi[0], yi[0]);
        end
        wait_done(0, 100, to);
        vecs++;
        if (to) begin
            errs++; $display("FAIL basic_done_timeout: no done within 100 cycles");
        end
        vecs++;
        if (busy[0] !== 1'b1) begin
            errs++; $display("FAIL busy_in_done_cycle: busy=%b want 1", busy[0]);
        end
        step();
        vecs++;
        if ({busy[0], done[0]} !== 2'b00) begin
            errs++; $display("FAIL after_done: busy=%b done=%b want 0 0", busy[0], done[0]);
        end
        vecs++;
        if (r_lag.size() - b_res != 3 || r_done - b_done != 1) begin
            errs++; $display("FAIL basic_counts: results=%0d dones=%0d want 3 1",
                r_lag.size() - b_res, r_done - b_done);
        end else begin
            for (int k = 0; k < 3; k++) begin
                vecs++;
                if ({r_lag[b_res+k], r_i[b_res+k], r_q[b_res+k]} !== {4'(k), 32'(30 + 10 * k), 32'd0}) begin
                    errs++; $display("FAIL basic_result%0d: got (%0d,%0d,%0d) want (%0d,%0d,0)",
                        k, r_lag[b_res+k], r_i[b_res+k], r_q[b_res+k], k, 30 + 10 * k);
                end
            end
        end
    endtask

    task automatic test_addr_sequence();
        int b_run, b_beat;
        bit to;
        b_run = r_runs.size(); b_beat = r_xa.size();
        r_skew = r_skew;
        out_rdy[0] = 1'b1;
        pulse_start(0);
        wait_done(0, 100, to);
        step();
        vecs++;
        if (to || r_runs.size() - b_run != 3 || r_xa.size() - b_beat != 12) begin
            errs++; $display("FAIL addr_beats: timeout=%0d runs=%0d beats=%0d want 0 3 12",
                to, r_runs.size() - b_run, r_xa.size() - b_beat);
        end else begin
            for (int r = 0; r < 3; r++) begin
                vecs++;
                if (r_runs[b_run+r] != LEN) begin
                    errs++; $display("FAIL run_len%0d: got %0d want %0d", r, r_runs[b_run+r], LEN);
                end
            end
            for (int b = 0; b < 4; b++) begin
                vecs++;
                if ({r_xa[b_beat+8+b], r_ya[b_beat+8+b]} !== {8'(b), 8'(b + 2)}) begin
                    errs++; $display("FAIL lag2_addr%0d: got x=%0d y=%0d want x=%0d y=%0d", b,
                        r_xa[b_beat+8+b], r_ya[b_beat+8+b], b, b + 2);
                end
            end
        end
        vecs++;
        if (r_skew != 0) begin
            errs++; $display("FAIL xy_valid_skew: got %0d cycles want 0", r_skew);
        end
    endtask

    task automatic test_backpressure();
        int b_res, b_done, lag1_hs;
        bit found, to;
        b_res = r_lag.size(); b_done = r_done;
        out_rdy[0] = 1'b1;
        found = 1'b0;
        pulse_start(0);
        for (int c = 0; c < 100; c++) begin
            if (so_vld[0] && out_lag[0] == 4'd1) begin found = 1'b1; break; end
            step();
        end
        out_rdy[0] = 1'b0;
        vecs++;
        if (!found) begin
            errs++; $display("FAIL bp_reach_lag1: lag 1 result not seen");
        end
        for (int c = 0; c < 5; c++) begin
            step();
            vecs++;
            if ({so_vld[0], out_lag[0], out_i[0]} !== {1'b1, 4'd1, 32'd40}) begin
                errs++; $display("FAIL bp_hold%0d: got vld=%b lag=%0d i=%0d want 1 1 40",
                    c, so_vld[0], out_lag[0], out_i[0]);
            end
        end
        out_rdy[0] = 1'b1;
        wait_done(0, 100, to);
        step();
        lag1_hs = 0;
        for (int r = b_res; r < r_lag.size(); r++) if (r_lag[r] == 4'd1) lag1_hs++;
        vecs++;
        if (to || lag1_hs != 1 || r_lag.size() - b_res != 3 || r_done - b_done != 1) begin
            errs++; $display("FAIL bp_handshakes: timeout=%0d lag1=%0d total=%0d dones=%0d want 0 1 3 1",
                to, lag1_hs, r_lag.size() - b_res, r_done - b_done);
        end
    endtask

    task automatic test_reset_mid();
        int b_res, b_done;
        bit found, to;
        b_res = r_lag.size(); b_done = r_done;
        out_rdy[0] = 1'b1;
        found = 1'b0;
        pulse_start(0);
        for (int c = 0; c < 100; c++) begin
            if (r_lag.size() - b_res == 1 && mx_vld[0]) begin found = 1'b1; break; end
            step();
        end
        vecs++;
        if (!found) begin
            errs++; $display("FAIL rst_reach_lag1_feed: not reached");
        end
        n_reset = 1'b0;
        step();
        vecs++;
        if ({busy[0], done[0], mx_vld[0], so_vld[0], pr_rdy[0], x_addr[0], y_addr[0], xi[0],
             yi[0], out_lag[0], out_i[0]} !== '0) begin
            errs++; $display("FAIL rst_mid_outputs: busy=%b vld=%b x=%0d y=%0d xi=%0d lag=%0d i=%0d want all 0",
                busy[0], mx_vld[0], x_addr[0], y_addr[0], xi[0], out_lag[0], out_i[0]);
        end
        n_reset = 1'b1;
        repeat (40) step();
        vecs++;
        if (r_done != b_done || r_lag.size() - b_res != 1 || busy[0] !== 1'b0) begin
            errs++; $display("FAIL rst_mid_abort: dones=%0d results=%0d busy=%b want 0 1 0",
                r_done - b_done, r_lag.size() - b_res, busy[0]);
        end
        b_res = r_lag.size();
        pulse_start(0);
        wait_done(0, 100, to);
        step();
        vecs++;
        if (to || r_lag.size() - b_res != 3) begin
            errs++; $display("FAIL rst_resweep_count: timeout=%0d results=%0d want 0 3",
                to, r_lag.size() - b_res);
        end else begin
            for (int k = 0; k < 3; k++) begin
                vecs++;
                if ({r_lag[b_res+k], r_i[b_res+k]} !== {4'(k), 32'(30 + 10 * k)}) begin
                    errs++; $display("FAIL rst_resweep%0d: got (%0d,%0d) want (%0d,%0d)",
                        k, r_lag[b_res+k], r_i[b_res+k], k, 30 + 10 * k);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int b_res, b_done;
        bit found, to;
        b_res = r_lag.size(); b_done = r_done;
        out_rdy[0] = 1'b1;
        found = 1'b0;
        pulse_start(0);
        for (int c = 0; c < 100; c++) begin
            if (pr_rdy[0]) begin found = 1'b1; break; end
            step();
        end
        vecs++;
        if (!found) begin
            errs++; $display("FAIL bb_reach_wait: WAIT not reached");
        end
        pulse_start(0);
        wait_done(0, 100, to);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        vecs++;
        if (busy[0] !== 1'b0) begin
            errs++; $display("FAIL start_in_done_cycle: busy=%b want 0", busy[0]);
        end
        repeat (30) step();
        vecs++;
        if (to || busy[0] !== 1'b0 || r_lag.size() - b_res != 3 || r_done - b_done != 1) begin
            errs++; $display("FAIL start_while_busy: timeout=%0d busy=%b results=%0d dones=%0d want 0 0 3 1",
                to, busy[0], r_lag.size() - b_res, r_done - b_done);
        end
    endtask

    task automatic test_single_lag();
        int hs;
        logic [3:0]  c_lag;
        logic [31:0] c_i, c_q;
        bit to;
        hs = 0; c_lag = 4'hf; c_i = '1; c_q = '1; to = 1'b1;
        out_rdy[1] = 1'b1;
        pulse_start(1);
        inj[1] = 1'b1;
        vecs++;
        if (pr_rdy[1] !== 1'b0) begin
            errs++; $display("FAIL single_tready_in_feed: got %b want 0", pr_rdy[1]);
        end
        step();
        inj[1] = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (so_vld[1] && out_rdy[1]) begin
                hs++; c_lag = out_lag[1]; c_i = out_i[1]; c_q = out_q[1];
            end
            if (done[1]) begin to = 1'b0; break; end
        end
        vecs++;
        if (to || hs != 1) begin
            errs++; $display("FAIL single_count: timeout=%0d handshakes=%0d want 0 1", to, hs);
        end
        vecs++;
        if ({c_lag, c_i, c_q} !== {4'd0, 32'd30, 32'd0}) begin
            errs++; $display("FAIL single_result: got (%0d,%0d,%0d) want (0,30,0)", c_lag, c_i, c_q);
        end
        step();
        vecs++;
        if (busy[1] !== 1'b0) begin
            errs++; $display("FAIL single_busy_end: busy=%b want 0", busy[1]);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; out_rdy[d] = 1'b0; inj[d] = 1'b0;
        end
        n_reset = 1'b0;
        test_reset();
        test_basic_sweep();
        test_addr_sequence();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_single_lag();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
